phase_timer: RTL

Parametrised interval timer for the traffic-light controller, generalising the fixed two-threshold phase counter. It counts enabled clock cycles up to a programmable terminal value and emits one-cycle pulses at `NUM_TAPS` programmable intermediate thresholds. It runs either periodically (auto-wrap) or one-shot (stop and hold). The light-sequencing FSM uses it to time green/amber/red phases without a dedicated counter per phase.

---
 rtl/tl_pkg.sv | 13 +
 rtl/phase_timer_tap_compare.sv | 31 +++
 rtl/phase_timer.sv | 84 ++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic-light controller timing blocks.
package tl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/phase_timer_tap_compare.sv
// One threshold detector: registers a pulse when an advance lands the counter on the tap value.
module tap_compare #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             adv_i,
    input  logic [WIDTH-1:0] next_cnt_i,
    input  logic [WIDTH-1:0] tap_val_i,
    output logic             hit_o
);

    logic hit_q;
    logic hit_d;

    // Only an advance, wrap or start is an entry; holding on a value never re-pulses.
    always_comb begin
        hit_d = adv_i && (next_cnt_i == tap_val_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/phase_timer.sv
// Programmable interval timer with per-tap entry pulses; periodic or one-shot operation.
module phase_timer
    import tl_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NUM_TAPS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      start,
    input  logic                      mode,
    input  logic [WIDTH-1:0]          period,
    input  logic [NUM_TAPS*WIDTH-1:0] tap_val,
    output logic [WIDTH-1:0]          count,
    output logic [NUM_TAPS-1:0]       tap_hit,
    output logic                      term,
    output logic                      busy
);

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             term_q, term_d;
    logic             busy_q;
    logic             adv;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        term_d  = 1'b0;
        adv     = 1'b0;
        if (start) begin
            state_d = RUN;
            count_d = '0;
            adv     = 1'b1;
        end else if ((state_q == RUN) && en) begin
            // >= lets a lowered period terminate at once instead of wrapping through 2^WIDTH.
            if (count_q >= period) begin
                term_d = 1'b1;
                if (mode == MODE_ONESHOT) begin
                    state_d = DONE;
                end else begin
                    count_d = '0;
                    adv     = 1'b1;
                end
            end else begin
                count_d = count_q + 1'b1;
                adv     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            term_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            term_q  <= term_d;
            busy_q  <= (state_d == RUN);
        end
    end

    for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
        tap_compare #(
            .WIDTH(WIDTH)
        ) u_tap (
            .clk_i      (clk),
            .rst_ni     (rst),
            .adv_i      (adv),
            .next_cnt_i (count_d),
            .tap_val_i  (tap_val[i*WIDTH +: WIDTH]),
            .hit_o      (tap_hit[i])
        );
    end

    assign count = count_q;
    assign term  = term_q;
    assign busy  = busy_q;

endmodule
